// File: rtl/seg7_scan4.sv
// Purpose: time-multiplexes a 16-bit packed hex digit word onto a common-anode 4-digit 7-segment display.
// Latency: 1 cycle from a slot pointer/prescaler change to AN/SEG/DP; digit data is snapshotted once per frame.
// Backpressure: ce low freezes prescaler, slot pointer and snapshot; the output registers keep loading every cycle.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of digits 3..1.
module seg7_scan4 #(
    parameter int SLOT_CYC  = 4,
    parameter int GUARD_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [15:0] DEC,
    input  logic [3:0]  DP_IN,
    input  logic        BLANK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic [15:0]      snap;
    logic [3:0]       dp_snap;
    logic             load_first;

    logic             slot_end;
    logic             frame_end;
    logic             snap_load;
    logic [3:0]       nib;
    logic [6:0]       seg_n;
    logic [3:0]       an_n;
    logic             dp_n;
    logic             lz_blank;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (ptr == 2'd3);
    // Load on the very first enabled cycle and at each frame boundary, so a frame never mixes data.
    assign snap_load = ce && (load_first || frame_end);

    // Prescaler, slot pointer, frame snapshot and registered display pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            ptr        <= 2'd0;
            snap       <= 16'h0000;
            dp_snap    <= 4'b0000;
            load_first <= 1'b1;
            AN         <= 4'b1111;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
        end else begin
            if (ce) begin
                if (slot_end) begin
                    cnt <= '0;
                    ptr <= ptr + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                load_first <= 1'b0;
            end
            if (snap_load) begin
                snap    <= DEC;
                dp_snap <= DP_IN;
            end
            AN  <= an_n;
            SEG <= seg_n;
            DP  <= dp_n;
        end
    end

    // Select the nibble for the active slot.
    always_comb begin
        nib = 4'h0;
        case (ptr)
            2'd0: nib = snap[3:0];
            2'd1: nib = snap[7:4];
            2'd2: nib = snap[11:8];
            2'd3: nib = snap[15:12];
            default: nib = 4'h0;
        endcase
    end

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        seg_n = 7'h7F;
        case (nib)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
    end

`ifdef SEG7_LZB_EN
    logic [3:0] lz;

    // A digit is a leading zero when it and every digit left of it are zero with no decimal point.
    always_comb begin
        lz       = 4'b0000;
        lz[3]    = (snap[15:12] == 4'h0) && !dp_snap[3];
        lz[2]    = lz[3] && (snap[11:8] == 4'h0) && !dp_snap[2];
        lz[1]    = lz[2] && (snap[7:4] == 4'h0) && !dp_snap[1];
        lz[0]    = 1'b0;
        lz_blank = lz[ptr];
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Anode select: one digit low at most, dark during the guard interval, on BLANK or leading-zero blanking.
    always_comb begin
        an_n = 4'b1111;
        dp_n = ~dp_snap[ptr];
        if ((cnt >= GUARD_LIM) && !BLANK && !lz_blank) begin
            an_n[ptr] = 1'b0;
        end
    end

endmodule
